// File: rtl/sda_action_ctrl_regs.sv
// sda_action_ctrl_regs: AXI4-Lite control register slave in front of the action top level.
// Turns a host CTRL start write into a go request and tracks the done handshake. It also
// drives the parameter buffer base and reports start/done/idle status.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*          AXI-Lite write channel (one write in flight)
//   s_axi_ar*/r*             AXI-Lite read channel (one read in flight)
//   go_0r / go_0a            action go request / acknowledge
//   done_0r / done_0a        action done request / acknowledge
//   param_buf_base           64-bit parameter base, writable only while idle
//   interrupt                registered completion interrupt
//
// Build option: define SDA_CTRL_IRQ_EN to add the GIE/IER/ISR registers and the interrupt
// output. Without it those registers read 0 and interrupt is tied low.
//
// Register map (byte offsets):
//   0x00 CTRL      bit0 start/busy, bit1 ap_done (clear on read), bit2 ap_idle
//   0x04 GIE, 0x08 IER, 0x0C ISR
//   0x10 PARAM_LO, 0x14 PARAM_HI
module sda_action_ctrl_regs #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter logic [63:0] PARAM_RESET = 64'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  go_0r,
  input  logic                  go_0a,
  input  logic                  done_0r,
  output logic                  done_0a,
  output logic [63:0]           param_buf_base,
  output logic                  interrupt
);

  localparam logic [3:0] AddrCtrl    = 4'h0;
  localparam logic [3:0] AddrParamLo = 4'h4;
  localparam logic [3:0] AddrParamHi = 4'h5;
`ifdef SDA_CTRL_IRQ_EN
  localparam logic [3:0] AddrGie     = 4'h1;
  localparam logic [3:0] AddrIer     = 4'h2;
  localparam logic [3:0] AddrIsr     = 4'h3;
`endif

  typedef enum logic [1:0] {StIdle, StGo, StRun, StDack} state_e;

  state_e      state_q, state_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  raddr_q, raddr_d;
  logic [63:0] param_q, param_d;
  logic        ap_done_q, ap_done_d;

  logic        wr_en, rd_accept, rd_done, start_wr, done_set;
  logic [3:0]  waddr;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign unused_addr = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign waddr     = s_axi_awaddr[5:2];
  // A write is taken only when no write is mid-handshake or awaiting its response.
  assign wr_en     = s_axi_awvalid & s_axi_wvalid & ~awready_q & ~bvalid_q;
  assign rd_accept = s_axi_arvalid & ~arready_q & ~rvalid_q;
  assign rd_done   = rvalid_q & s_axi_rready;
  assign start_wr  = wr_en & (waddr == AddrCtrl) & s_axi_wstrb[0] & s_axi_wdata[0];

  // Action handshake FSM
  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    unique case (state_q)
      StIdle: if (start_wr) state_d = StGo;
      StGo:   if (go_0a) state_d = done_0r ? StDack : StRun;
      StRun:  if (done_0r) state_d = StDack;
      StDack: begin
        if (!done_0r) begin
          state_d  = StIdle;
          done_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Parameter base only moves while idle so the action sees a stable value.
  always_comb begin
    param_d = param_q;
    if (wr_en && state_q == StIdle) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) begin
          if (waddr == AddrParamLo) param_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
          if (waddr == AddrParamHi) param_d[32+8*b +: 8] = s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Setting ap_done takes priority over the clear-on-read.
  assign ap_done_d = done_set | (ap_done_q & ~(rd_done & (raddr_q == AddrCtrl)));

  assign awready_d = wr_en;
  assign bvalid_d  = awready_q | (bvalid_q & ~s_axi_bready);
  assign arready_d = rd_accept;
  assign raddr_d   = rd_accept ? s_axi_araddr[5:2] : raddr_q;
  assign rvalid_d  = arready_q | (rvalid_q & ~s_axi_rready);
  assign rdata_d   = arready_q ? rd_mux : rdata_q;

`ifdef SDA_CTRL_IRQ_EN
  logic gie_q, gie_d, ier_q, ier_d, isr_q, isr_d, irq_q;

  always_comb begin
    gie_d = gie_q;
    ier_d = ier_q;
    isr_d = isr_q;
    if (wr_en && s_axi_wstrb[0]) begin
      if (waddr == AddrGie) gie_d = s_axi_wdata[0];
      if (waddr == AddrIer) ier_d = s_axi_wdata[0];
      if (waddr == AddrIsr) isr_d = isr_q ^ s_axi_wdata[0];
    end
    if (done_set && ier_q) isr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gie_q <= 1'b0;
      ier_q <= 1'b0;
      isr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      gie_q <= gie_d;
      ier_q <= ier_d;
      isr_q <= isr_d;
      irq_q <= gie_q & isr_q;
    end
  end

  assign interrupt = irq_q;
`else
  assign interrupt = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (raddr_q)
      AddrCtrl:    rd_mux[2:0] = {state_q == StIdle, ap_done_q, state_q != StIdle};
      AddrParamLo: rd_mux = param_q[31:0];
      AddrParamHi: rd_mux = param_q[63:32];
`ifdef SDA_CTRL_IRQ_EN
      AddrGie:     rd_mux[0] = gie_q;
      AddrIer:     rd_mux[0] = ier_q;
      AddrIsr:     rd_mux[0] = isr_q;
`endif
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      param_q   <= PARAM_RESET;
      ap_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      param_q   <= param_d;
      ap_done_q <= ap_done_d;
    end
  end

  assign s_axi_awready  = awready_q;
  assign s_axi_wready   = awready_q;
  assign s_axi_bvalid   = bvalid_q;
  assign s_axi_bresp    = 2'b00;
  assign s_axi_arready  = arready_q;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rresp    = 2'b00;
  assign go_0r          = (state_q == StGo);
  assign done_0a        = (state_q == StDack);
  assign param_buf_base = param_q;

endmodule

// File: tb/tb_sda_action_ctrl_regs.sv
// Self-checking bench for sda_action_ctrl_regs: directed scenarios, then random register
// traffic compared against a register-level model of the host-visible state.
module tb_sda_action_ctrl_regs;

  localparam logic [63:0] PRst = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        go_0r, go_0a, done_0r, done_0a, interrupt;
  logic [63:0] param_buf_base;

  int n_checks = 0;
  int n_errors = 0;
  int go_count = 0;
  int done_count = 0;
  int run_delay = 0;
  int act_cnt;
  logic go_seen;

  // Host-visible model state
  logic [63:0] m_param;
  logic        m_done, m_gie, m_ier, m_isr;

  sda_action_ctrl_regs #(
    .ADDR_WIDTH  (6),
    .PARAM_RESET (PRst)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_axi_awaddr   (awaddr),
    .s_axi_awvalid  (awvalid),
    .s_axi_awready  (awready),
    .s_axi_wdata    (wdata),
    .s_axi_wstrb    (wstrb),
    .s_axi_wvalid   (wvalid),
    .s_axi_wready   (wready),
    .s_axi_bresp    (bresp),
    .s_axi_bvalid   (bvalid),
    .s_axi_bready   (bready),
    .s_axi_araddr   (araddr),
    .s_axi_arvalid  (arvalid),
    .s_axi_arready  (arready),
    .s_axi_rdata    (rdata),
    .s_axi_rresp    (rresp),
    .s_axi_rvalid   (rvalid),
    .s_axi_rready   (rready),
    .go_0r          (go_0r),
    .go_0a          (go_0a),
    .done_0r        (done_0r),
    .done_0a        (done_0a),
    .param_buf_base (param_buf_base),
    .interrupt      (interrupt)
  );

  always #5 clk = ~clk;

  // Loopback action: acks go one cycle late, raises done run_delay cycles after the ack,
  // drops done once done_0a is seen.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_0a   <= 1'b0;
      done_0r <= 1'b0;
      act_cnt <= 0;
    end else begin
      go_0a <= go_0r;
      if (go_0r && !go_0a) act_cnt <= run_delay;
      else if (act_cnt != 0) act_cnt <= act_cnt - 1;
      if (done_0a) done_0r <= 1'b0;
      else if (go_0r && !go_0a && run_delay == 0) done_0r <= 1'b1;
      else if (act_cnt == 1) done_0r <= 1'b1;
    end
  end

  always @(posedge go_0r) go_count++;
  always @(negedge done_0a) done_count++;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    check_eq("aw_w_ready", {awready, wready}, 2'b11);
    go_seen = go_0r;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("bvalid_rise", {bvalid, bresp}, 3'b100);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bvalid_hold", bvalid, 1'b1);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_eq("bvalid_clear", bvalid, 1'b0);
  endtask

  // Leaves rvalid pending when keep is set (rready held low).
  task automatic axi_read(input logic [5:0] addr, input logic keep, output logic [31:0] data);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = !keep;
    @(negedge clk);
    check_eq("arready", arready, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    check_eq("rvalid", {rvalid, rresp}, 3'b100);
    data = rdata;
    if (!keep) begin
      @(negedge clk);
      rready = 1'b0;
      check_eq("rvalid_clear", rvalid, 1'b0);
    end
  endtask

  task automatic wait_done(input int snap);
    int n = 0;
    while (done_count == snap && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_timeout", done_count != snap, 1'b1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_read(input int w);
    case (w)
      0: model_read = {29'b0, 1'b1, m_done, 1'b0};
      4: model_read = m_param[31:0];
      5: model_read = m_param[63:32];
`ifdef SDA_CTRL_IRQ_EN
      1: model_read = {31'b0, m_gie};
      2: model_read = {31'b0, m_ier};
      3: model_read = {31'b0, m_isr};
`endif
      default: model_read = 32'h0;
    endcase
  endfunction

  initial begin
    logic [31:0] rd, held;
    logic [63:0] pb;
    int snap, gsnap, w, hold;
    logic [31:0] d;
    logic [3:0]  s;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {awready, wready, bvalid, arready, rvalid, go_0r, done_0a, interrupt},
             8'h00);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_param", param_buf_base, PRst);
    reset_n = 1'b1;
    axi_read(6'h00, 1'b0, rd);
    check_eq("ctrl_after_rst", rd, 32'h4);

    // Parameter write, response stalled 3 cycles
    axi_write(6'h10, 32'hDEAD_0000, 4'hF, 0);
    axi_write(6'h14, 32'h0000_0001, 4'hF, 3);
    check_eq("param_base", param_buf_base, 64'h1_DEAD_0000);
    axi_read(6'h10, 1'b0, rd);
    check_eq("param_lo_rd", rd, 32'hDEAD_0000);

    // Full action run with immediate done
    run_delay = 0;
    snap = done_count;
    gsnap = go_count;
    axi_write(6'h00, 32'h1, 4'h1, 0);
    check_eq("go_next_cycle", go_seen, 1'b1);
    wait_done(snap);
    check_eq("one_go", go_count - gsnap, 1);
    axi_read(6'h00, 1'b0, rd);
    check_eq("ctrl_done", rd, 32'h6);
    axi_read(6'h00, 1'b0, rd);
    check_eq("ctrl_done_cleared", rd, 32'h4);

    // Busy guards while running
    run_delay = 60;
    snap = done_count;
    gsnap = go_count;
    axi_write(6'h00, 32'h1, 4'h1, 0);
    axi_write(6'h10, 32'h5, 4'hF, 0);
    axi_write(6'h00, 32'h1, 4'h1, 0);
    check_eq("busy_param", param_buf_base, 64'h1_DEAD_0000);
    axi_read(6'h00, 1'b0, rd);
    check_eq("ctrl_busy", rd, 32'h1);
    wait_done(snap);
    check_eq("busy_no_second_go", go_count - gsnap, 1);
    axi_read(6'h00, 1'b0, rd);
    check_eq("ctrl_done2", rd, 32'h6);

    // Clear/set race: CTRL read completes in the cycle ap_done is set
    run_delay = 10;
    snap = done_count;
    axi_write(6'h00, 32'h1, 4'h1, 0);
    axi_read(6'h00, 1'b1, held);
    check_eq("race_held_busy", held, 32'h1);
    for (int i = 0; i < 200; i++) begin
      if (done_0a && !done_0r) break;
      @(negedge clk);
    end
    check_eq("race_rdata_stable", {rvalid, rdata}, {1'b1, held});
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check_eq("race_done_seen", done_count != snap, 1'b1);
    axi_read(6'h00, 1'b0, rd);
    check_eq("race_set_wins", rd, 32'h6);
    axi_read(6'h00, 1'b0, rd);
    check_eq("race_cleared", rd, 32'h4);

`ifdef SDA_CTRL_IRQ_EN
    axi_write(6'h04, 32'h1, 4'h1, 0);
    axi_write(6'h08, 32'h1, 4'h1, 0);
    run_delay = 2;
    snap = done_count;
    axi_write(6'h00, 32'h1, 4'h1, 0);
    wait_done(snap);
    repeat (2) @(negedge clk);
    check_eq("irq_set", interrupt, 1'b1);
    axi_write(6'h0C, 32'h1, 4'h1, 0);
    repeat (2) @(negedge clk);
    check_eq("irq_clear", interrupt, 1'b0);
    axi_write(6'h04, 32'h0, 4'h1, 0);
    axi_write(6'h08, 32'h0, 4'h1, 0);
`else
    run_delay = 2;
    snap = done_count;
    axi_write(6'h04, 32'h1, 4'h1, 0);
    axi_write(6'h08, 32'h1, 4'h1, 0);
    axi_write(6'h00, 32'h1, 4'h1, 0);
    wait_done(snap);
    repeat (2) @(negedge clk);
    check_eq("irq_tied_low", interrupt, 1'b0);
    axi_read(6'h04, 1'b0, rd);
    check_eq("gie_reads_zero", rd, 32'h0);
`endif
    axi_read(6'h00, 1'b0, rd);

    // Reset mid-action
    run_delay = 40;
    axi_write(6'h00, 32'h1, 4'h1, 0);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_handshake", {go_0r, done_0a, awready, bvalid, arready, rvalid}, 6'h00);
    check_eq("midrst_param", param_buf_base, PRst);
    check_eq("midrst_irq", interrupt, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    axi_read(6'h00, 1'b0, rd);
    check_eq("midrst_ctrl", rd, 32'h4);

    // Random register traffic against the model
    m_param = PRst;
    m_done = 1'b0;
    m_gie = 1'b0;
    m_ier = 1'b0;
    m_isr = 1'b0;
    for (int it = 0; it < 60; it++) begin
      w = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        hold = $urandom_range(0, 2);
        run_delay = $urandom_range(0, 4);
        if (w == 0 && $urandom_range(0, 1) == 1) begin
          d[0] = 1'b1;
          s[0] = 1'b1;
        end
        snap = done_count;
        axi_write(6'(w * 4), d, s, hold);
        if (w == 0 && s[0] && d[0]) begin
          wait_done(snap);
          m_done = 1'b1;
          if (m_ier) m_isr = 1'b1;
        end
        if (w == 4 || w == 5) begin
          pb = m_param;
          for (int b = 0; b < 4; b++) begin
            if (s[b]) pb[(w - 4) * 32 + 8 * b +: 8] = d[8 * b +: 8];
          end
          m_param = pb;
        end
`ifdef SDA_CTRL_IRQ_EN
        if (s[0] && w == 1) m_gie = d[0];
        if (s[0] && w == 2) m_ier = d[0];
        if (s[0] && w == 3) m_isr = m_isr ^ d[0];
`endif
        check_eq("rnd_param", param_buf_base, m_param);
      end else begin
        axi_read(6'(w * 4), 1'b0, rd);
        check_eq("rnd_read", rd, model_read(w));
        if (w == 0) m_done = 1'b0;
      end
      repeat (2) @(negedge clk);
      check_eq("rnd_irq", interrupt, m_gie & m_isr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sda_action_ctrl_regs.md
Name: sda_action_ctrl_regs

Overview:
- Host-facing AXI4-Lite control register slave. Sits directly upstream of the teak kernel action top level.
- Converts host register writes into the action go request, and tracks the action done handshake.
- Drives the action's s_axi-side parameter base (param_buf_base) and exposes start/done/idle status to the host.
- Completion is signalled either by polled status or, optionally, by an interrupt.

Parameters:
ADDR_WIDTH, 6, AXI-Lite address width; only bits [5:2] are decoded.
PARAM_RESET, 64'h0, reset value of the parameter base register.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response, always 2'b00
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response, always 2'b00
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
go_0r  out  1  action go request
go_0a  in  1  action go acknowledge
done_0r  in  1  action done request
done_0a  out  1  action done acknowledge
param_buf_base  out  64  parameter buffer base to the action
interrupt  out  1  level interrupt (tied 0 without the optional feature)

Behaviour:
- Reset: asynchronous and active-low; all registers clear immediately on reset_n low. Every output is 0 except param_buf_base, which resets to PARAM_RESET. The FSM resets to IDLE.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 ap_start (W1 sets, reads as busy), bit1 ap_done (clear-on-read), bit2 ap_idle (RO).
  - 0x04 GIE, 0x08 IER, 0x0C ISR (see Optional Feature).
  - 0x10 PARAM_LO = param_buf_base[31:0].
  - 0x14 PARAM_HI = param_buf_base[63:32].
  - Other offsets read 0; writes to them are accepted and ignored.
- Write channel:
  - Accept only when awvalid&wvalid are both high and bvalid=0.
  - Sampled at cycle N: awready=wready=1 for exactly one cycle at N+1, and the register update takes effect at N+1.
  - bvalid rises at N+2 and holds until bready; the next write cannot start while bvalid=1.
- wstrb applies per byte on PARAM_LO/HI. The CTRL start bit requires wstrb[0]=1.
- Read channel:
  - Sampled arvalid at cycle N: arready=1 at N+1; rvalid and rdata are valid at N+2.
  - rdata is held stable until rready. One outstanding read at a time.
- ap_done clears in the cycle the CTRL read completes (rvalid&rready). If done is set in the same cycle, set wins.
- FSM states: IDLE, GO, RUN, DACK.
  - IDLE: ap_idle=1. A CTRL write with wdata[0]=1 -> GO, with go_0r=1 from the next cycle.
  - GO: hold go_0r=1 until go_0a=1, then go_0r=0. If done_0r=1 in that same cycle -> DACK, otherwise -> RUN.
  - RUN: done_0r=1 -> DACK, with done_0a=1 from the next cycle.
  - DACK: hold done_0a=1 until done_0r=0. Then done_0a=0, set ap_done, -> IDLE.
- A start write in any state other than IDLE is ignored.
- PARAM_LO/HI writes are ignored unless the FSM is in IDLE, so param_buf_base is stable throughout an action.
- Simultaneous read and write are serviced independently on their own channels.
- Reset asserted mid-action returns the FSM to IDLE and drops go_0r/done_0a immediately; the action is reset by the same net.

Optional Feature:
- Macro: SDA_CTRL_IRQ_EN.
- Defined:
  - GIE bit0 is the global enable; IER bit0 enables the done interrupt.
  - ISR bit0 is set on action completion when IER[0]=1, and is toggle-on-write-1.
  - interrupt = GIE[0] & ISR[0], registered.
- Undefined: GIE, IER and ISR read 0 and ignore writes; interrupt is tied 0.

Test Plan:
- Reset: pull reset_n low asynchronously mid-cycle -> all outputs 0 at once, param_buf_base=PARAM_RESET; read CTRL after release -> 32'h4.
- Parameter write: PARAM_LO=32'hDEAD_0000 then PARAM_HI=32'h1 -> param_buf_base=64'h1_DEAD_0000; bvalid held 3 cycles with bready low, then completes.
- Action run: write CTRL=1 against a loopback action (go_0a asserts with done_0r) -> go_0r rises one cycle after the write; full four-phase go/done completes; CTRL reads 32'h6 once, then 32'h4.
- Busy guards: while in RUN, write PARAM_LO=32'h5 and CTRL=1 -> param_buf_base unchanged, no second go_0r; CTRL reads 32'h1.
- Clear/set race: CTRL read completes in the same cycle ap_done is set -> ap_done remains 1 on the next read.
- With SDA_CTRL_IRQ_EN: GIE=1, IER=1, run an action -> interrupt=1; write ISR=1 -> interrupt=0. Without the macro: interrupt stays 0 throughout.
